// File: rtl/tape_fsk_player.sv
// tape_fsk_player: plays .c10 bytes from SDRAM as a 1200/2400 Hz FSK cassette signal.
// Defining TAPE_MOTOR_EN adds a motor input that gates play at byte boundaries.
module tape_fsk_player #(
    parameter int HALF0      = 1667,
    parameter int HALF1      = 833,
    parameter int FETCH_WAIT = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        play,
    input  logic        rewind,
`ifdef TAPE_MOTOR_EN
    input  logic        motor,
`endif
    input  logic [24:0] tape_len,
    output logic [24:0] sdram_addr,
    output logic        sdram_rd,
    input  logic [7:0]  sdram_data,
    output logic        data,
    output logic [2:0]  status
);
    localparam int HMAX = HALF0 > HALF1 ? HALF0 : HALF1;
    localparam int CW   = $clog2(HMAX + 1);
    localparam int FW   = $clog2(FETCH_WAIT + 1);

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, HIGH, LOW, DONE} state_t;

    state_t        state_q, state_d;
    logic [24:0]   ptr_q, ptr_d, addr_q, addr_d;
    logic [7:0]    shreg_q, shreg_d, buf_q, buf_d;
    logic          bufv_q, bufv_d, rd_q, rd_d, fetch_q, fetch_d, data_q, data_d;
    logic [2:0]    bit_q, bit_d, status_q, status_d;
    logic [CW-1:0] hcnt_q, hcnt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          run, sample, start;

    function automatic logic [CW-1:0] half(input logic b);
        return b ? CW'(HALF1 - 1) : CW'(HALF0 - 1);
    endfunction

`ifdef TAPE_MOTOR_EN
    assign run = play & motor;
`else
    assign run = play;
`endif
    assign sample = fetch_q & ~rd_q & (fcnt_q == '0);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        shreg_d = shreg_q;
        buf_d   = buf_q;
        bufv_d  = bufv_q;
        bit_d   = bit_q;
        hcnt_d  = hcnt_q;
        data_d  = data_q;
        rd_d    = 1'b0;
        fetch_d = fetch_q;
        fcnt_d  = fcnt_q;
        start   = 1'b0;
        // one fetch timer serves both the main fetch and the prefetch; they never overlap
        if (rd_q)
            fcnt_d = FW'(FETCH_WAIT - 1);
        else if (fetch_q && fcnt_q != '0)
            fcnt_d = fcnt_q - FW'(1);
        if (sample) begin
            fetch_d = 1'b0;
            if (state_q != WAIT) begin
                buf_d  = sdram_data;
                bufv_d = 1'b1;
            end
        end
        case (state_q)
            IDLE: if (run) begin
                if (ptr_q >= tape_len) begin
                    state_d = DONE;
                end else if (bufv_q) begin
                    shreg_d = buf_q;
                    bufv_d  = 1'b0;
                    start   = 1'b1;
                end else begin
                    state_d = FETCH;
                    rd_d    = 1'b1;
                    fetch_d = 1'b1;
                    addr_d  = ptr_q;
                end
            end
            FETCH: state_d = WAIT;
            WAIT: if (sample) begin
                shreg_d = sdram_data;
                start   = 1'b1;
            end
            HIGH: if (hcnt_q == '0) begin
                state_d = LOW;
                data_d  = 1'b0;
                hcnt_d  = half(shreg_q[0]);
            end else begin
                hcnt_d = hcnt_q - CW'(1);
            end
            LOW: if (hcnt_q != '0) begin
                hcnt_d = hcnt_q - CW'(1);
            end else if (bit_q != 3'd7) begin
                bit_d   = bit_q + 3'd1;
                shreg_d = shreg_q >> 1;
                state_d = HIGH;
                data_d  = 1'b1;
                hcnt_d  = half(shreg_q[1]);
            end else begin
                ptr_d  = ptr_q + 25'd1;
                data_d = 1'b0;
                if (ptr_d >= tape_len)
                    state_d = DONE;
                else if (run && bufv_q) begin
                    shreg_d = buf_q;
                    bufv_d  = 1'b0;
                    start   = 1'b1;
                end else
                    state_d = IDLE;
            end
            DONE: data_d = 1'b0;
            default: state_d = IDLE;
        endcase
        // a new byte starts its first high half and prefetches its successor in the same cycle
        if (start) begin
            state_d = HIGH;
            data_d  = 1'b1;
            bit_d   = 3'd0;
            hcnt_d  = half(shreg_d[0]);
            if ({1'b0, ptr_d} + 26'd1 < {1'b0, tape_len}) begin
                rd_d    = 1'b1;
                fetch_d = 1'b1;
                addr_d  = ptr_d + 25'd1;
            end
        end
        if (rewind) begin
            state_d = IDLE;
            ptr_d   = '0;
            bufv_d  = 1'b0;
            fetch_d = 1'b0;
            rd_d    = 1'b0;
            data_d  = 1'b0;
        end
        status_d = {state_d == DONE, state_d inside {FETCH, WAIT, HIGH, LOW}, fetch_d};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            addr_q   <= '0;
            shreg_q  <= '0;
            buf_q    <= '0;
            bufv_q   <= 1'b0;
            bit_q    <= '0;
            hcnt_q   <= '0;
            data_q   <= 1'b0;
            rd_q     <= 1'b0;
            fetch_q  <= 1'b0;
            fcnt_q   <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            addr_q   <= addr_d;
            shreg_q  <= shreg_d;
            buf_q    <= buf_d;
            bufv_q   <= bufv_d;
            bit_q    <= bit_d;
            hcnt_q   <= hcnt_d;
            data_q   <= data_d;
            rd_q     <= rd_d;
            fetch_q  <= fetch_d;
            fcnt_q   <= fcnt_d;
            status_q <= status_d;
        end
    end

    assign sdram_addr = addr_q;
    assign sdram_rd   = rd_q;
    assign data       = data_q;
    assign status     = status_q;
endmodule

// File: tb/tb_tape_fsk_player.sv
// tb_tape_fsk_player: directed checks of tape_fsk_player against an SDRAM model that
// presents read data only in the cycle FETCH_WAIT clocks after each strobe.
module tb_tape_fsk_player;
    localparam int H0  = 10;
    localparam int H1  = 5;
    localparam int FWT = 8;

    typedef struct {
        int          len;
        logic [23:0] bytes;
        int          nrd;
        logic [2:0]  fin;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n, play, rewind;
    logic [24:0] tape_len, sdram_addr;
    logic        sdram_rd, data;
    logic [7:0]  sdram_data = 8'h3C;
    logic [2:0]  status;
`ifdef TAPE_MOTOR_EN
    logic        motor = 1'b1;
`endif

    logic [7:0]  mem [8];
    logic [24:0] rd_log [64];
    logic [24:0] rd_addr = '0;
    int          rd_total = 0, rd_cyc = 0, hold_err = 0, cyc = 0;
    logic        pend = 1'b0;
    int          n_chk = 0, n_fail = 0;

    tape_fsk_player #(.HALF0(H0), .HALF1(H1), .FETCH_WAIT(FWT)) dut (
        .clk(clk), .reset_n(reset_n), .play(play), .rewind(rewind),
`ifdef TAPE_MOTOR_EN
        .motor(motor),
`endif
        .tape_len(tape_len), .sdram_addr(sdram_addr), .sdram_rd(sdram_rd),
        .sdram_data(sdram_data), .data(data), .status(status)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // data is valid only in the exact sample cycle; garbage otherwise
    always @(negedge clk) begin
        if (pend && cyc == rd_cyc + FWT) begin
            sdram_data = mem[rd_addr[2:0]];
            if (sdram_addr != rd_addr) hold_err++;
            pend = 1'b0;
        end else
            sdram_data = 8'h3C;
        if (sdram_rd) begin
            if (rd_total < 64) rd_log[rd_total] = sdram_addr;
            rd_total++;
            rd_cyc  = cyc;
            rd_addr = sdram_addr;
            pend    = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_byte(input logic [7:0] b, input int drop_at, inout int err);
        int k = 0;
        for (int j = 0; j < 8; j++) begin
            int h;
            h = b[j] ? H1 : H0;
            for (int p = 0; p < 2 * h; p++) begin
                @(negedge clk);
                k++;
                if (data !== (p < h) || status[1] !== 1'b1) err++;
                if (k == drop_at) play = 1'b0;
            end
        end
    endtask

    task automatic prep(input int len, input logic [23:0] bytes);
        play   = 1'b0;
        rewind = 1'b1;
        @(negedge clk);
        rewind   = 1'b0;
        tape_len = 25'(len);
        for (int i = 0; i < 3; i++) mem[i] = bytes[8*i +: 8];
        @(negedge clk);
    endtask

    task automatic wait_first_high(inout int err);
        for (int i = 0; i < FWT; i++) begin
            @(negedge clk);
            if (data !== 1'b0) err++;
        end
    endtask

    task automatic run_vec(input vec_t v, input int r);
        int base, err;
        base = rd_total;
        err  = 0;
        prep(v.len, v.bytes);
        base = rd_total;
        play = 1'b1;
        @(negedge clk);
        if (v.len != 0) begin
            chk($sformatf("strobe%0d", r), {sdram_rd, sdram_addr}, {1'b1, 25'd0});
            chk($sformatf("fetch_status%0d", r), status, 3'b011);
            wait_first_high(err);
            for (int i = 0; i < v.len; i++) check_byte(v.bytes[8*i +: 8], -1, err);
            @(negedge clk);
            chk($sformatf("wave%0d", r), err, 0);
        end
        chk($sformatf("final_status%0d", r), status, v.fin);
        chk($sformatf("final_data%0d", r), data, 0);
        chk($sformatf("rd_count%0d", r), rd_total - base, v.nrd);
        for (int i = 0; i < v.nrd; i++) chk($sformatf("rd_addr%0d_%0d", r, i), rd_log[base+i], i);
        play = 1'b0;
    endtask

    initial begin
        vec_t vecs [4];
        int   base, err;
        vecs[0] = '{1, 24'h000001, 1, 3'b100};
        vecs[1] = '{3, 24'hAA00FF, 3, 3'b100};
        vecs[2] = '{2, 24'h00815A, 2, 3'b100};
        vecs[3] = '{0, 24'h000000, 0, 3'b100};

        reset_n  = 1'b0;
        play     = 1'b0;
        rewind   = 1'b0;
        tape_len = '0;
        repeat (3) @(negedge clk);
        chk("rst_status", status, 3'b000);
        chk("rst_data", data, 0);
        chk("rst_rd", sdram_rd, 0);
        chk("rst_addr", sdram_addr, 0);
        reset_n = 1'b1;

        for (int r = 0; r < 4; r++) run_vec(vecs[r], r);

        // play dropped in bit 3 of byte 0, resumed later from the buffer
        err = 0;
        prep(3, 24'h18A50F);
        base = rd_total;
        play = 1'b1;
        @(negedge clk);
        wait_first_high(err);
        check_byte(8'h0F, 3 * 2 * H1 + 2, err);
        @(negedge clk);
        chk("pause_status", status, 3'b000);
        chk("pause_data", data, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (data !== 1'b0 || status !== 3'b000) err++;
        end
        chk("pause_rd_count", rd_total - base, 2);
        play = 1'b1;
        check_byte(8'hA5, -1, err);
        check_byte(8'h18, -1, err);
        @(negedge clk);
        chk("pause_wave", err, 0);
        chk("pause_final", status, 3'b100);
        chk("pause_rd_total", rd_total - base, 3);
        for (int i = 0; i < 3; i++) chk($sformatf("pause_addr%0d", i), rd_log[base+i], i);

        // rewind while a prefetch is outstanding
        err = 0;
        prep(3, 24'h030201);
        play = 1'b1;
        @(negedge clk);
        wait_first_high(err);
        @(negedge clk);
        chk("prefetch_strobe", {data, sdram_rd, sdram_addr}, {2'b11, 25'd1});
        @(negedge clk);
        @(negedge clk);
        rewind = 1'b1;
        @(negedge clk);
        chk("rewind_data", data, 0);
        chk("rewind_status", status, 3'b000);
        rewind = 1'b0;
        play   = 1'b0;
        repeat (10) @(negedge clk);
        chk("late_sample_ignored", status, 3'b000);
        play = 1'b1;
        @(negedge clk);
        chk("refetch_addr0", {sdram_rd, sdram_addr}, {1'b1, 25'd0});
        wait_first_high(err);
        check_byte(8'h01, -1, err);
        chk("rewind_wave", err, 0);

        // reset during the main fetch wait
        err = 0;
        prep(2, 24'h002211);
        play = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midfetch_rst_status", status, 3'b000);
        chk("midfetch_rst_out", {data, sdram_rd, sdram_addr}, 0);
        reset_n = 1'b1;
        play    = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_late_sample", status, 3'b000);
        play = 1'b1;
        @(negedge clk);
        chk("rst_refetch", {sdram_rd, sdram_addr}, {1'b1, 25'd0});
        wait_first_high(err);
        check_byte(8'h11, -1, err);
        check_byte(8'h22, -1, err);
        @(negedge clk);
        chk("rst_wave", err, 0);
        chk("rst_final", status, 3'b100);
        play = 1'b0;

`ifdef TAPE_MOTOR_EN
        prep(1, 24'h000001);
        base  = rd_total;
        motor = 1'b0;
        play  = 1'b1;
        repeat (5) @(negedge clk);
        chk("motor_off_status", status, 3'b000);
        chk("motor_off_rd", rd_total - base, 0);
        motor = 1'b1;
        @(negedge clk);
        chk("motor_on_fetch", {sdram_rd, sdram_addr}, {1'b1, 25'd0});
`endif

        chk("addr_hold", hold_err, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/tape_fsk_player.md
TAPE_FSK_PLAYER -- requirements
Module: tape_fsk_player

Interface
REQ-001 SHALL have parameter HALF0, default 1667, meaning clocks per half-cycle of a "0" bit (1200 Hz at 4 MHz).
REQ-002 SHALL have parameter HALF1, default 833, meaning clocks per half-cycle of a "1" bit (2400 Hz at 4 MHz).
REQ-003 SHALL have parameter FETCH_WAIT, default 8, meaning clocks from the sdram_rd pulse to the sdram_data sample.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, 4 MHz tape clock domain.
REQ-005 SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port play, input, 1 bit: level; 1 = run, 0 = pause.
REQ-007 SHALL have port rewind, input, 1 bit: level; while 1, return to tape start.
REQ-008 SHALL have port tape_len, input, 25 bits: number of loaded .c10 bytes.
REQ-009 SHALL have port sdram_addr, output, 25 bits: byte address of the fetch.
REQ-010 SHALL have port sdram_rd, output, 1 bit: one-cycle read strobe.
REQ-011 SHALL have port sdram_data, input, 8 bits: read data.
REQ-012 SHALL have port data, output, 1 bit: FSK cassette signal to the computer's cassette input.
REQ-013 SHALL have port status, output, 3 bits: {eot, playing, fetching}.

Function
REQ-014 Byte pointer ptr (25 b) SHALL select the current byte; bytes play in ascending address order, each byte LSB first.
REQ-015 Each bit SHALL drive data=1 for H clocks then data=0 for H clocks, where H=HALF1 for a 1 bit and H=HALF0 for a 0 bit; consecutive bits SHALL abut with no gap cycles.
REQ-016 FSM states SHALL be IDLE, FETCH, WAIT, HIGH, LOW and DONE.
REQ-017 IDLE->FETCH SHALL occur when play=1, no byte is buffered and ptr<tape_len; IDLE->DONE SHALL occur when play=1 and ptr>=tape_len, which includes tape_len=0.
REQ-018 FETCH SHALL assert sdram_rd for exactly 1 cycle with sdram_addr=ptr; sdram_addr SHALL hold until the sample.
REQ-019 WAIT SHALL sample sdram_data exactly FETCH_WAIT clocks after the sdram_rd cycle into the shift register, then go to HIGH.
REQ-020 At the first clock of bit 0 of each byte, when ptr+1<tape_len, the block SHALL issue a prefetch of ptr+1 with the same strobe and timing rules into a one-byte buffer with a valid flag; FETCH_WAIT < 2*HALF1 SHALL hold by construction.
REQ-021 After the LOW half of bit 7, ptr SHALL increment. If ptr=tape_len, the next state SHALL be DONE. Otherwise, if play=1 and the buffer is valid, the buffer SHALL load and HIGH begins on the next clock; if play=0, the next state SHALL be IDLE with the buffer retained.
REQ-022 play SHALL be evaluated only at byte boundaries; deasserting play mid-byte SHALL complete the byte.
REQ-023 DONE SHALL drive data=0 and eot=1, and SHALL be left only by rewind or reset.
REQ-024 rewind=1 SHALL, in the same clock from any state, set ptr=0, clear the buffer valid flag, drop any pending sample, force data=0 and go to IDLE; rewind SHALL take priority over play and over end-of-tape.
REQ-025 status[1] (playing) SHALL be 1 in HIGH, LOW, FETCH and WAIT; status[0] (fetching) SHALL be 1 from an sdram_rd strobe until its sample completes.
REQ-026 A change of tape_len during play SHALL take effect at the next end-of-tape comparison.

Reset
REQ-027 When reset_n=0 at a clk edge, the block SHALL set: state IDLE, ptr=0, buffer invalid, data=0, sdram_rd=0, sdram_addr=0, status=3'b000.
REQ-028 A reset asserted mid-bit or mid-fetch SHALL abort immediately; any sample that arrives later SHALL be ignored.

Configuration
REQ-029 With macro TAPE_MOTOR_EN defined, the block SHALL add input port motor (1 bit), and the run condition at every byte boundary SHALL be play & motor.
REQ-030 Without TAPE_MOTOR_EN, the motor port SHALL be absent and the run condition SHALL be play alone.

Verification
REQ-031 Directed scenario: tape_len=1, byte 0x01, play=1 -> data shows 1 bit of 833 high/833 low, then 7 bits of 1667 high/1667 low, then status=3'b100 and data=0.
REQ-032 Directed scenario: tape_len=3, bytes 0xFF,0x00,0xAA, FETCH_WAIT=8 -> exactly 3 sdram_rd pulses at addresses 0, 1, 2; no gap cycles between bytes; each rd-to-sample interval is 8 clocks.
REQ-033 Directed scenario: play drops midway through bit 3 of byte 0 -> byte 0 completes, state is IDLE, data=0 with no further strobes; when play rises again, byte 1 starts on the next clock from the buffer.
REQ-034 Directed scenario: rewind pulse during WAIT of a prefetch -> data=0 at the next clock, ptr=0, the late sample is ignored, and the next play re-fetches address 0.
REQ-035 Directed scenario: tape_len=0 with play=1 -> DONE within 2 clocks, no sdram_rd pulse, status=3'b100.
REQ-036 Directed scenario: with TAPE_MOTOR_EN, motor=0 and play=1 -> stays in IDLE; when motor rises, the fetch of address 0 occurs within 2 clocks.
